// File: rtl/jtag_pkg.sv
// Shared JTAG TAP definitions: state encoding, instruction opcodes, IR capture
// pattern and the 1149.1 next-state function.
package jtag_pkg;

  localparam int unsigned OPC_WIDTH = 4;
  localparam int unsigned ID_WIDTH  = 32;

  localparam logic [OPC_WIDTH-1:0] OPC_EXTEST         = 4'b0000;
  localparam logic [OPC_WIDTH-1:0] OPC_SAMPLE_PRELOAD = 4'b0001;
  localparam logic [OPC_WIDTH-1:0] OPC_IDCODE         = 4'b1110;
  localparam logic [OPC_WIDTH-1:0] OPC_BYPASS         = 4'b1111;

  localparam logic [1:0] IR_CAPTURE = 2'b01;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET = 4'hF,
    RUN_TEST_IDLE    = 4'hC,
    SELECT_DR        = 4'h7,
    CAPTURE_DR       = 4'h6,
    SHIFT_DR         = 4'h2,
    EXIT1_DR         = 4'h1,
    PAUSE_DR         = 4'h3,
    EXIT2_DR         = 4'h0,
    UPDATE_DR        = 4'h5,
    SELECT_IR        = 4'h4,
    CAPTURE_IR       = 4'hE,
    SHIFT_IR         = 4'hA,
    EXIT1_IR         = 4'h9,
    PAUSE_IR         = 4'hB,
    EXIT2_IR         = 4'h8,
    UPDATE_IR        = 4'hD
  } tap_state_e;

  // Standard TAP transition table.
  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    case (s)
      TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    n = tms ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_DR:        n = tms ? SELECT_IR        : CAPTURE_DR;
      CAPTURE_DR:       n = tms ? EXIT1_DR         : SHIFT_DR;
      SHIFT_DR:         n = tms ? EXIT1_DR         : SHIFT_DR;
      EXIT1_DR:         n = tms ? UPDATE_DR        : PAUSE_DR;
      PAUSE_DR:         n = tms ? EXIT2_DR         : PAUSE_DR;
      EXIT2_DR:         n = tms ? UPDATE_DR        : SHIFT_DR;
      UPDATE_DR:        n = tms ? SELECT_DR        : RUN_TEST_IDLE;
      SELECT_IR:        n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       n = tms ? EXIT1_IR         : SHIFT_IR;
      SHIFT_IR:         n = tms ? EXIT1_IR         : SHIFT_IR;
      EXIT1_IR:         n = tms ? UPDATE_IR        : PAUSE_IR;
      PAUSE_IR:         n = tms ? EXIT2_IR         : PAUSE_IR;
      EXIT2_IR:         n = tms ? UPDATE_IR        : SHIFT_IR;
      UPDATE_IR:        n = tms ? SELECT_DR        : RUN_TEST_IDLE;
      default:          n = TEST_LOGIC_RESET;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state TAP controller; state and per-state strobes are registered together
// so every strobe is high exactly while the FSM sits in that state.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       tms,
  output tap_state_e state,
  output logic       shift_dr,
  output logic       shift_ir,
  output logic       capture_dr,
  output logic       capture_ir,
  output logic       update_dr,
  output logic       update_ir,
  output logic       test_logic_reset
);

  tap_state_e next_state;

  assign next_state = tap_next(state, tms);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= TEST_LOGIC_RESET;
      shift_dr         <= 1'b0;
      shift_ir         <= 1'b0;
      capture_dr       <= 1'b0;
      capture_ir       <= 1'b0;
      update_dr        <= 1'b0;
      update_ir        <= 1'b0;
      test_logic_reset <= 1'b1;
    end else begin
      state            <= next_state;
      shift_dr         <= (next_state == SHIFT_DR);
      shift_ir         <= (next_state == SHIFT_IR);
      capture_dr       <= (next_state == CAPTURE_DR);
      capture_ir       <= (next_state == CAPTURE_IR);
      update_dr        <= (next_state == UPDATE_DR);
      update_ir        <= (next_state == UPDATE_IR);
      test_logic_reset <= (next_state == TEST_LOGIC_RESET);
    end
  end

endmodule

// File: rtl/jtag_tap_controller.sv
// JTAG TAP with IR, IDCODE, BYPASS and boundary-scan routing (EXTEST,
// SAMPLE_PRELOAD); unknown opcodes fall back to BYPASS.
module jtag_tap_controller
  import jtag_pkg::*;
#(
  parameter int unsigned IR_WIDTH     = 4,
  parameter logic [31:0] IDCODE_VALUE = 32'h1000_563D
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_en,
  output logic                bsr_sin,
  input  logic                bsr_sout,
  output logic                bsr_shift,
  output logic                testing,
  output logic [IR_WIDTH-1:0] ir_value
);

  tap_state_e            state;
  logic                  shift_dr;
  logic                  shift_ir;
  logic                  capture_dr;
  logic                  capture_ir;
  logic                  update_dr;
  logic                  update_ir;
  logic                  test_logic_reset;

  logic [IR_WIDTH-1:0]   ir_shift;
  logic [ID_WIDTH-1:0]   id_reg;
  logic                  bypass_reg;
  logic                  enter_tlr;
  logic                  sel_extest;
  logic                  sel_sample;
  logic                  sel_idcode;
  logic                  sel_bsr;
  logic [1:0]            unused_fsm;

  jtag_tap_fsm u_fsm (
    .clock            (clock),
    .reset            (reset),
    .tms              (tms),
    .state            (state),
    .shift_dr         (shift_dr),
    .shift_ir         (shift_ir),
    .capture_dr       (capture_dr),
    .capture_ir       (capture_ir),
    .update_dr        (update_dr),
    .update_ir        (update_ir),
    .test_logic_reset (test_logic_reset)
  );

  // Boundary-scan cells latch their own update; the TAP has nothing to do there.
  assign unused_fsm = {update_dr, test_logic_reset};

  // Clears ir_value/testing on the same edge the FSM lands in Test-Logic-Reset.
  assign enter_tlr  = (tap_next(state, tms) == TEST_LOGIC_RESET);

  assign sel_extest = (ir_value == IR_WIDTH'(OPC_EXTEST));
  assign sel_sample = (ir_value == IR_WIDTH'(OPC_SAMPLE_PRELOAD));
  assign sel_idcode = (ir_value == IR_WIDTH'(OPC_IDCODE));
  assign sel_bsr    = sel_extest | sel_sample;

  assign bsr_sin    = tdi;
  assign tdo_en     = shift_dr | shift_ir;
  assign bsr_shift  = shift_dr & sel_bsr;

  always_comb begin
    tdo = 1'b0;
    if (shift_ir) begin
      tdo = ir_shift[0];
    end else if (shift_dr) begin
      if (sel_bsr) begin
        tdo = bsr_sout;
      end else if (sel_idcode) begin
        tdo = id_reg[0];
      end else begin
        tdo = bypass_reg;
      end
    end
  end

  // Instruction path: capture/shift stage plus the latched instruction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ir_shift <= '0;
      ir_value <= IR_WIDTH'(OPC_IDCODE);
      testing  <= 1'b0;
    end else begin
      if (capture_ir) begin
        ir_shift <= IR_WIDTH'(IR_CAPTURE);
      end else if (shift_ir) begin
        ir_shift <= {tdi, ir_shift[IR_WIDTH-1:1]};
      end
      if (enter_tlr) begin
        ir_value <= IR_WIDTH'(OPC_IDCODE);
        testing  <= 1'b0;
      end else if (update_ir) begin
        ir_value <= ir_shift;
        testing  <= (ir_shift == IR_WIDTH'(OPC_EXTEST));
      end
    end
  end

  // Data registers owned by the TAP: ID word and single-bit bypass.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_reg     <= IDCODE_VALUE;
      bypass_reg <= 1'b0;
    end else begin
      if (sel_idcode) begin
        if (capture_dr) begin
          id_reg <= IDCODE_VALUE;
        end else if (shift_dr) begin
          id_reg <= {tdi, id_reg[ID_WIDTH-1:1]};
        end
      end
      if (!sel_idcode && !sel_bsr) begin
        if (capture_dr) begin
          bypass_reg <= 1'b0;
        end else if (shift_dr) begin
          bypass_reg <= tdi;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Directed bench for jtag_tap_controller: reset, IDCODE scan, pause/resume,
// bypass, tms-reset, IR capture with EXTEST and mid-scan reset.
module tb_jtag_tap_controller;
  import jtag_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       tms = 1'b1;
  logic       tdi = 1'b0;
  logic       tdo;
  logic       tdo_en;
  logic       bsr_sin;
  logic       bsr_sout = 1'b0;
  logic       bsr_shift;
  logic       testing;
  logic [3:0] ir_value;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] idc = 32'h1000_563D;

  jtag_tap_controller dut (
    .clock     (clock),
    .reset     (reset),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo),
    .tdo_en    (tdo_en),
    .bsr_sin   (bsr_sin),
    .bsr_sout  (bsr_sout),
    .bsr_shift (bsr_shift),
    .testing   (testing),
    .ir_value  (ir_value)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input logic t_tms, input logic t_tdi);
    tms = t_tms;
    tdi = t_tdi;
    @(posedge clock);
    #1;
  endtask

  task automatic goto_shift_dr();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic load_ir(input logic [3:0] code);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(i == 3, code[i]);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (tdo !== 1'b0) begin n_fail++; $display("FAIL reset_tdo: got %b want 0", tdo); end
    n_cmp++; if (tdo_en !== 1'b0) begin n_fail++; $display("FAIL reset_tdo_en: got %b want 0", tdo_en); end
    n_cmp++; if (bsr_shift !== 1'b0) begin n_fail++; $display("FAIL reset_bsr_shift: got %b want 0", bsr_shift); end
    n_cmp++; if (testing !== 1'b0) begin n_fail++; $display("FAIL reset_testing: got %b want 0", testing); end
    n_cmp++; if (ir_value !== 4'b1110) begin n_fail++; $display("FAIL reset_ir: got %b want 1110", ir_value); end
    @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    n_cmp++; if (dut.u_fsm.state !== TEST_LOGIC_RESET) begin n_fail++; $display("FAIL tlr_hold: got %h want %h", dut.u_fsm.state, TEST_LOGIC_RESET); end
    tick(1'b0, 1'b0);
    n_cmp++; if (dut.u_fsm.state !== RUN_TEST_IDLE) begin n_fail++; $display("FAIL rti_state: got %h want %h", dut.u_fsm.state, RUN_TEST_IDLE); end
    n_cmp++; if (ir_value !== 4'b1110) begin n_fail++; $display("FAIL rti_ir: got %b want 1110", ir_value); end
    n_cmp++; if (testing !== 1'b0) begin n_fail++; $display("FAIL rti_testing: got %b want 0", testing); end
    n_cmp++; if (tdo_en !== 1'b0) begin n_fail++; $display("FAIL rti_tdo_en: got %b want 0", tdo_en); end
  endtask

  task automatic test_idcode();
    goto_shift_dr();
    n_cmp++; if (tdo_en !== 1'b1) begin n_fail++; $display("FAIL id_tdo_en: got %b want 1", tdo_en); end
    for (int i = 0; i < 32; i++) begin
      n_cmp++;
      if (tdo !== idc[i]) begin n_fail++; $display("FAIL id_bit%0d: got %b want %b", i, tdo, idc[i]); end
      tick(i == 31, 1'b0);
    end
    n_cmp++; if (tdo_en !== 1'b0) begin n_fail++; $display("FAIL id_exit_tdo_en: got %b want 0", tdo_en); end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_pause_resume();
    goto_shift_dr();
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (tdo !== idc[i]) begin n_fail++; $display("FAIL pr_bit%0d: got %b want %b", i, tdo, idc[i]); end
      tick(i == 7, 1'b1);
    end
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    n_cmp++; if (dut.u_fsm.state !== PAUSE_DR) begin n_fail++; $display("FAIL pr_pause_state: got %h want %h", dut.u_fsm.state, PAUSE_DR); end
    n_cmp++; if (tdo_en !== 1'b0) begin n_fail++; $display("FAIL pr_pause_tdo_en: got %b want 0", tdo_en); end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 8; i < 16; i++) begin
      n_cmp++;
      if (tdo !== idc[i]) begin n_fail++; $display("FAIL pr_bit%0d: got %b want %b", i, tdo, idc[i]); end
      tick(i == 15, 1'b0);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_bypass();
    logic [3:0] codes [2];
    logic [4:0] din;
    logic [4:0] dexp;
    codes[0] = 4'b1111;
    codes[1] = 4'b0101;
    din  = 5'b00110;
    dexp = 5'b01100;
    for (int c = 0; c < 2; c++) begin
      load_ir(codes[c]);
      n_cmp++; if (ir_value !== codes[c]) begin n_fail++; $display("FAIL byp_ir%0d: got %b want %b", c, ir_value, codes[c]); end
      goto_shift_dr();
      n_cmp++; if (bsr_shift !== 1'b0) begin n_fail++; $display("FAIL byp_bsr_shift%0d: got %b want 0", c, bsr_shift); end
      for (int j = 0; j < 5; j++) begin
        n_cmp++;
        if (tdo !== dexp[j]) begin n_fail++; $display("FAIL byp%0d_cycle%0d: got %b want %b", c, j, tdo, dexp[j]); end
        tick(j == 4, din[j]);
      end
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
    end
  endtask

  task automatic test_tms_reset();
    load_ir(4'b1111);
    goto_shift_dr();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    n_cmp++; if (dut.u_fsm.state !== TEST_LOGIC_RESET) begin n_fail++; $display("FAIL tms5_state: got %h want %h", dut.u_fsm.state, TEST_LOGIC_RESET); end
    n_cmp++; if (ir_value !== 4'b1110) begin n_fail++; $display("FAIL tms5_ir: got %b want 1110", ir_value); end
    tick(1'b0, 1'b0);
  endtask

  task automatic test_ir_capture_extest();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    n_cmp++; if (tdo_en !== 1'b1) begin n_fail++; $display("FAIL irc_tdo_en: got %b want 1", tdo_en); end
    n_cmp++; if (tdo !== 1'b1) begin n_fail++; $display("FAIL irc_bit0: got %b want 1", tdo); end
    tick(1'b0, 1'b0);
    n_cmp++; if (tdo !== 1'b0) begin n_fail++; $display("FAIL irc_bit1: got %b want 0", tdo); end
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    n_cmp++; if (testing !== 1'b0) begin n_fail++; $display("FAIL ext_pre_testing: got %b want 0", testing); end
    tick(1'b0, 1'b0);
    n_cmp++; if (ir_value !== 4'b0000) begin n_fail++; $display("FAIL ext_ir: got %b want 0000", ir_value); end
    n_cmp++; if (testing !== 1'b1) begin n_fail++; $display("FAIL ext_testing: got %b want 1", testing); end
    n_cmp++; if (bsr_shift !== 1'b0) begin n_fail++; $display("FAIL ext_rti_bsr_shift: got %b want 0", bsr_shift); end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    n_cmp++; if (bsr_shift !== 1'b0) begin n_fail++; $display("FAIL ext_cap_bsr_shift: got %b want 0", bsr_shift); end
    tick(1'b0, 1'b0);
    n_cmp++; if (bsr_shift !== 1'b1) begin n_fail++; $display("FAIL ext_shift_bsr_shift: got %b want 1", bsr_shift); end
    bsr_sout = 1'b1;
    #1;
    n_cmp++; if (tdo !== 1'b1) begin n_fail++; $display("FAIL ext_tdo_hi: got %b want 1", tdo); end
    bsr_sout = 1'b0;
    tdi = 1'b1;
    #1;
    n_cmp++; if (tdo !== 1'b0) begin n_fail++; $display("FAIL ext_tdo_lo: got %b want 0", tdo); end
    n_cmp++; if (bsr_sin !== 1'b1) begin n_fail++; $display("FAIL ext_bsr_sin: got %b want 1", bsr_sin); end
    tick(1'b1, 1'b0);
    n_cmp++; if (bsr_shift !== 1'b0) begin n_fail++; $display("FAIL ext_exit_bsr_shift: got %b want 0", bsr_shift); end
    tick(1'b0, 1'b0);
    n_cmp++; if (testing !== 1'b1) begin n_fail++; $display("FAIL ext_pause_testing: got %b want 1", testing); end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    n_cmp++; if (bsr_shift !== 1'b1) begin n_fail++; $display("FAIL ext_resume_bsr_shift: got %b want 1", bsr_shift); end
  endtask

  task automatic test_reset_mid_scan();
    bsr_sout = 1'b1;
    #1;
    n_cmp++; if (tdo !== 1'b1) begin n_fail++; $display("FAIL mid_pre_tdo: got %b want 1", tdo); end
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (testing !== 1'b0) begin n_fail++; $display("FAIL mid_testing: got %b want 0", testing); end
    n_cmp++; if (bsr_shift !== 1'b0) begin n_fail++; $display("FAIL mid_bsr_shift: got %b want 0", bsr_shift); end
    n_cmp++; if (tdo_en !== 1'b0) begin n_fail++; $display("FAIL mid_tdo_en: got %b want 0", tdo_en); end
    n_cmp++; if (tdo !== 1'b0) begin n_fail++; $display("FAIL mid_tdo: got %b want 0", tdo); end
    n_cmp++; if (ir_value !== 4'b1110) begin n_fail++; $display("FAIL mid_ir: got %b want 1110", ir_value); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    bsr_sout = 1'b0;
    tick(1'b0, 1'b0);
    n_cmp++; if (dut.u_fsm.state !== RUN_TEST_IDLE) begin n_fail++; $display("FAIL mid_rti: got %h want %h", dut.u_fsm.state, RUN_TEST_IDLE); end
  endtask

  initial begin
    test_reset();
    test_idcode();
    test_pause_resume();
    test_bypass();
    test_tms_reset();
    test_ir_capture_extest();
    test_reset_mid_scan();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/jtag_tap_controller.md
JTAG_TAP_CONTROLLER -- requirements
Module: jtag_tap_controller

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 4, instruction register width in bits.
REQ-002 SHALL have parameter IDCODE_VALUE, default 32'h1000_563D, device identification word; bit 0 SHALL be 1.
REQ-003 SHALL have input clock, 1 bit, test clock; all state changes on its rising edge.
REQ-004 SHALL have input reset, 1 bit, asynchronous, active-high.
REQ-005 SHALL have input tms, 1 bit, test mode select.
REQ-006 SHALL have input tdi, 1 bit, serial test data in.
REQ-007 SHALL have output tdo, 1 bit, serial test data out.
REQ-008 SHALL have output tdo_en, 1 bit, high only in Shift-IR or Shift-DR.
REQ-009 SHALL have output bsr_sin, 1 bit, serial input to the first boundary-scan cell; equals tdi.
REQ-010 SHALL have input bsr_sout, 1 bit, serial output of the last boundary-scan cell.
REQ-011 SHALL have output bsr_shift, 1 bit, clock-enable for the boundary-scan chain; high in Shift-DR when EXTEST or SAMPLE_PRELOAD is active.
REQ-012 SHALL have output testing, 1 bit, drives the cells' testing pin; high while EXTEST is the current instruction.
REQ-013 SHALL have output ir_value, IR_WIDTH bits, the current instruction.

Function
REQ-014 SHALL implement the 16-state IEEE 1149.1 TAP state machine: Test-Logic-Reset, Run-Test/Idle, Select-DR/IR, Capture-DR/IR, Shift-DR/IR, Exit1-DR/IR, Pause-DR/IR, Exit2-DR/IR, Update-DR/IR.
REQ-015 SHALL advance the state on each rising clock edge per tms, with standard transitions.
REQ-016 SHALL reach Test-Logic-Reset after 5 consecutive tms=1 cycles from any state.
REQ-017 SHALL decode instructions as EXTEST=0000, SAMPLE_PRELOAD=0001, IDCODE=1110 and BYPASS=1111; any other code SHALL act as BYPASS.
REQ-018 SHALL load the IR shift stage with binary ...01 (LSB=1, bit1=0, remaining bits 0) in Capture-IR.
REQ-019 SHALL shift the IR stage right in Shift-IR, with tdi entering the MSB.
REQ-020 SHALL copy the IR stage to ir_value in Update-IR; ir_value SHALL not change in any other state.
REQ-021 SHALL set ir_value to IDCODE in Test-Logic-Reset.
REQ-022 SHALL, with IDCODE active, load IDCODE_VALUE into the 32-bit ID register in Capture-DR and shift it right with tdi entering the MSB in Shift-DR.
REQ-023 SHALL, with BYPASS active, clear the 1-bit bypass register in Capture-DR and load it from tdi in Shift-DR.
REQ-024 SHALL, with EXTEST or SAMPLE_PRELOAD active, route bsr_sout to tdo in Shift-DR.
REQ-025 SHALL drive tdo from the selected register's LSB (IR stage in Shift-IR) combinationally, and drive 0 when tdo_en is low.
REQ-026 SHALL pass tms=0/1 through the Pause and Exit states without corrupting the shift registers.
REQ-027 SHALL keep testing stable through every DR scan; testing SHALL change only at Update-IR or on entry to Test-Logic-Reset.

Reset
REQ-028 SHALL, on reset assertion, immediately force Test-Logic-Reset, ir_value=IDCODE, IR stage=0, bypass=0, ID register=IDCODE_VALUE.
REQ-029 SHALL hold tdo=0, tdo_en=0, bsr_shift=0 and testing=0 during reset, including when reset is asserted mid-scan.

Structure
REQ-030 SHALL take the state encoding enum, the instruction opcode constants and the IR capture pattern from a shared package, jtag_pkg.
REQ-031 SHALL place the 16-state FSM in one sub-module, jtag_tap_fsm, with outputs state, shift_dr, shift_ir, capture_dr, capture_ir, update_dr, update_ir and test_logic_reset.

Verification
REQ-032 Bench SHALL check: reset, then 5 tms=1 cycles, then tms=0 -> Run-Test/Idle, ir_value=4'b1110, testing=0.
REQ-033 Bench SHALL check: go to Shift-DR after reset and shift out 32 bits -> tdo sequence equals 32'h1000_563D LSB first.
REQ-034 Bench SHALL check: load IR=1111 and shift 0,1,1,0 in Shift-DR -> tdo is 0 in the first cycle, then the tdi bits one cycle late.
REQ-035 Bench SHALL check: shift IR capture -> first two tdo bits are 1,0; load IR=0000 -> testing=1 after Update-IR and bsr_shift=1 only in Shift-DR.
REQ-036 Bench SHALL check: assert reset during Shift-DR under EXTEST -> testing, bsr_shift and tdo_en are 0 in the same cycle and ir_value=IDCODE.
